// File: rtl/gen_clk_mon_pkg.sv
// Shared types and helpers for the generated-clock frequency monitor.
// Holds the FSM state encoding, the settle length and the pass/fail bound helpers.
// Optional sticky-fail feature is selected by GEN_CLK_MON_STICKY_EN in the top.
package gen_clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } mon_state_t;

  // Cycles spent flushing the synchronizer before counting starts.
  localparam int SETTLE_CYCLES = 3;

  // Lower pass bound; clamps at zero when the tolerance exceeds the target.
  function automatic int fail_lo(input int exp_cnt, input int tol);
    return (exp_cnt > tol) ? (exp_cnt - tol) : 0;
  endfunction

  // Upper pass bound.
  function automatic int fail_hi(input int exp_cnt, input int tol);
    return exp_cnt + tol;
  endfunction

endpackage

// File: rtl/gen_clk_mon_sync.sv
// Brings the generated clock into the clk domain as data and flags its rising edges.
// Latency: 2 cycles through the synchronizer, rise is combinational off the third flop.
// No backpressure: free-running sampler.
module gen_clk_mon_sync (
  input  logic clk,
  input  logic rst,
  input  logic mon_clk,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Two synchronizer flops followed by the edge-detect history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/gen_clk_monitor.sv
// Counts rising edges of a generated clock over a fixed clk window and flags out-of-range counts.
// Latency: done pulses in the cycle after edge T+4+WINDOW for a start sampled at edge T.
// start is ignored while busy; optional sticky fail via GEN_CLK_MON_STICKY_EN.
module gen_clk_monitor
  import gen_clk_mon_pkg::*;
#(
  parameter int WINDOW  = 256,
  parameter int CNT_W   = 16,
  parameter int EXP_CNT = 128,
  parameter int TOL     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             fail
`ifdef GEN_CLK_MON_STICKY_EN
  ,
  input  logic             fail_clr,
  output logic             fail_sticky
`endif
);

  localparam int TMR_W = $clog2(WINDOW);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W:0]   FAIL_LO     = (CNT_W+1)'(fail_lo(EXP_CNT, TOL));
  localparam logic [CNT_W:0]   FAIL_HI     = (CNT_W+1)'(fail_hi(EXP_CNT, TOL));
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic             cont_q;
  logic             cont_nxt;
  logic [CNT_W-1:0] acc;
  logic             rise;
  logic             fail_nxt;

  gen_clk_mon_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .mon_clk (mon_clk),
    .rise    (rise)
  );

  // Extended-width compare so EXP_CNT+TOL cannot wrap.
  assign fail_nxt = ({1'b0, acc} < FAIL_LO) | ({1'b0, acc} > FAIL_HI);
  assign busy     = (state != IDLE);

  // Phase sequencing: settle once, then measure/report, looping when continuous.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    cont_nxt  = cont_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          tmr_nxt   = SETTLE_LAST;
          cont_nxt  = cont;
        end
      end
      SETTLE: begin
        if (tmr == '0) begin
          state_nxt = MEASURE;
          tmr_nxt   = WIN_LAST;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      MEASURE: begin
        if (tmr == '0) begin
          state_nxt = REPORT;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end
      REPORT: begin
        if (cont_q) begin
          state_nxt = MEASURE;
          tmr_nxt   = WIN_LAST;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, phase timer and latched continuous-mode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tmr    <= '0;
      cont_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      cont_q <= cont_nxt;
    end
  end

  // Saturating edge accumulator; held at zero outside the measurement window.
  always_ff @(posedge clk) begin
    if (rst || (state != MEASURE)) begin
      acc <= '0;
    end else if (rise && (acc != CNT_MAX)) begin
      acc <= acc + CNT_W'(1);
    end
  end

  // Result registers update only at the end of REPORT and hold in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      done  <= 1'b0;
      count <= '0;
      fail  <= 1'b0;
    end else begin
      done <= (state == REPORT);
      if (state == REPORT) begin
        count <= acc;
        fail  <= fail_nxt;
      end
    end
  end

`ifdef GEN_CLK_MON_STICKY_EN
  // Sticky fail: a failing report takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_sticky <= 1'b0;
    end else if ((state == REPORT) && fail_nxt) begin
      fail_sticky <= 1'b1;
    end else if (fail_clr) begin
      fail_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_gen_clk_monitor.sv
// Directed bench for gen_clk_monitor: default instance plus a low-target instance for the upper bound.
// Stimulus changes and output sampling both happen on the falling clk edge.
// Sticky-fail checks compile in when GEN_CLK_MON_STICKY_EN is defined.
module tb_gen_clk_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        mon_gen = 1'b0;
  logic        mon_burst = 1'b0;
  logic        mon_clk;
  int          mode = 0;   // 0 stuck low, 1 div2, 2 div4, 3 directed burst
  int          ph = 0;

  logic        busy, done, fail;
  logic [15:0] count;
  logic        busy_hi, done_hi, fail_hi_o;
  logic [15:0] count_hi;
`ifdef GEN_CLK_MON_STICKY_EN
  logic        fail_clr = 1'b0;
  logic        fail_sticky, fail_sticky_hi;
  logic        cap_sticky;
`endif

  int          checks = 0;
  int          errors = 0;
  int          lat, ndone;
  logic [15:0] cap_count, cap_count_hi;
  logic        cap_fail, cap_fail_hi, cap_busy;
  int          t_done [3];
  int          nd;

  assign mon_clk = (mode == 3) ? mon_burst : mon_gen;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    case (mode)
      1: mon_gen = ~mon_gen;
      2: begin ph = (ph + 1) % 4; mon_gen = (ph >= 2); end
      default: mon_gen = 1'b0;
    endcase
  end

  gen_clk_monitor dut (
    .clk     (clk),
    .rst     (rst),
    .mon_clk (mon_clk),
    .start   (start),
    .cont    (cont),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .fail    (fail)
`ifdef GEN_CLK_MON_STICKY_EN
    ,
    .fail_clr    (fail_clr),
    .fail_sticky (fail_sticky)
`endif
  );

  gen_clk_monitor #(.WINDOW(256), .CNT_W(16), .EXP_CNT(64), .TOL(2)) dut_hi (
    .clk     (clk),
    .rst     (rst),
    .mon_clk (mon_clk),
    .start   (start),
    .cont    (cont),
    .busy    (busy_hi),
    .done    (done_hi),
    .count   (count_hi),
    .fail    (fail_hi_o)
`ifdef GEN_CLK_MON_STICKY_EN
    ,
    .fail_clr    (fail_clr),
    .fail_sticky (fail_sticky_hi)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One single-shot run: pulse start, optionally drive a burst, a second start, or a clear.
  task automatic measure(input int n_burst, input int restart_at, input int clr_at);
    lat   = -1;
    ndone = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      if (n_burst >= 0) mon_burst = (k >= 3) && (k < 3 + 2 * n_burst) && (((k - 3) % 2) == 0);
      start = (k == restart_at);
`ifdef GEN_CLK_MON_STICKY_EN
      fail_clr = (k == clr_at);
`endif
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) begin
          lat          = k;
          cap_count    = count;
          cap_fail     = fail;
          cap_busy     = busy;
          cap_count_hi = count_hi;
          cap_fail_hi  = fail_hi_o;
`ifdef GEN_CLK_MON_STICKY_EN
          cap_sticky   = fail_sticky;
`endif
        end
      end
    end
    mon_burst = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_fail", fail, 0);
    rst = 1'b0;
    @(negedge clk);

    // Divide-by-2 input, nominal pass
    mode = 1;
    measure(-1, 0, 0);
    check("div2_latency", lat, 260);
    check("div2_ndone", ndone, 1);
    check("div2_count", cap_count, 128);
    check("div2_fail", cap_fail, 0);
    check("div2_busy_at_done", cap_busy, 0);
    check("div2_hi_fail", cap_fail_hi, 1);
    check("hold_count", count, 128);

    // Stuck low
    mode = 0;
    measure(-1, 0, 0);
    check("stuck_count", cap_count, 0);
    check("stuck_fail", cap_fail, 1);
`ifdef GEN_CLK_MON_STICKY_EN
    check("stuck_sticky", cap_sticky, 1);
`endif

    // Passing window after a failure keeps the sticky flag, then clear it
    mode = 1;
    measure(-1, 0, 0);
    check("pass2_fail", cap_fail, 0);
`ifdef GEN_CLK_MON_STICKY_EN
    check("sticky_held", fail_sticky, 1);
    @(negedge clk); fail_clr = 1'b1;
    @(negedge clk); fail_clr = 1'b0;
    check("sticky_cleared", fail_sticky, 0);
`endif

    // clk/4 input; clear lands in the REPORT cycle of a failing window
    mode = 2;
    measure(-1, 0, 259);
    check("div4_count", cap_count, 64);
    check("div4_fail", cap_fail, 1);
    check("div4_hi_fail", cap_fail_hi, 0);
`ifdef GEN_CLK_MON_STICKY_EN
    check("sticky_set_wins", cap_sticky, 1);
`endif

    // Directed bursts around both tolerance edges
    mode = 3;
    measure(126, 0, 0);
    check("b126_count", cap_count, 126);
    check("b126_fail", cap_fail, 0);
    measure(125, 0, 0);
    check("b125_count", cap_count, 125);
    check("b125_fail", cap_fail, 1);
    measure(66, 0, 0);
    check("b66_hi_count", cap_count_hi, 66);
    check("b66_hi_fail", cap_fail_hi, 0);
    measure(67, 0, 0);
    check("b67_hi_count", cap_count_hi, 67);
    check("b67_hi_fail", cap_fail_hi, 1);

    // start while busy is ignored
    mode = 1;
    measure(-1, 50, 0);
    check("restart_ndone", ndone, 1);
    check("restart_latency", lat, 260);
    check("restart_count", cap_count, 128);

    // Continuous mode; cont dropped right after start must not stop it
    nd = 0;
    @(negedge clk); start = 1'b1; cont = 1'b1;
    @(negedge clk); start = 1'b0; cont = 1'b0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (nd < 3) t_done[nd] = k;
        nd++;
        check("cont_count", count, 128);
      end
    end
    check("cont_ndone", nd, 3);
    check("cont_first", t_done[0], 260);
    check("cont_gap1", t_done[1] - t_done[0], 257);
    check("cont_gap2", t_done[2] - t_done[1], 257);
    check("cont_busy_mid", busy, 1);

    // Reset mid-MEASURE aborts
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_count", count, 0);
    check("abort_fail", fail, 0);
    rst = 1'b0;
    nd = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("abort_no_done", nd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
